uart_tx_arbiter: RTL

- Shares one uart_tx byte stream between NUM_SRC independent AXI-stream byte sources.
- Grants are round-robin and packet-locked: a granted source keeps the UART until it sends tlast, or until MAX_BURST bytes have been sent.
- A registered output stage drives the uart_tx tvalid/tready/tdata input directly.
- Sits between per-client byte producers (debug log, status reporter, etc.) and the single shared uart_tx instance.

---
 rtl/uart_tx_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked mux of NUM_SRC byte streams onto one registered uart_tx stream
module uart_tx_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC-1:0]            s_tvalid,
   output logic [NUM_SRC-1:0]            s_tready,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_SRC-1:0]            s_tlast,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic [DATA_WIDTH-1:0]         m_tdata,
   output logic [$clog2(NUM_SRC)-1:0]    grant_id,
   output logic                          busy
);
   localparam int GW = $clog2(NUM_SRC);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                state_q, state_d;
   logic [GW-1:0]         grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d, sel, idx;
   logic [7:0]            cnt_q, cnt_d;
   logic                  m_tvalid_q, m_tvalid_d;
   logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
   logic                  found, ready, in_xfer, out_xfer, rel;

   assign ready    = (state_q == GRANT) && (!m_tvalid_q || m_tready);
   assign s_tready = ready ? (NUM_SRC'(1) << grant_id_q) : '0;
   assign in_xfer  = ready && s_tvalid[grant_id_q];
   assign out_xfer = m_tvalid_q && m_tready;
   assign rel      = in_xfer && (s_tlast[grant_id_q] || cnt_q == 8'(MAX_BURST - 1));
   assign m_tvalid = m_tvalid_q;
   assign m_tdata  = m_tdata_q;
   assign grant_id = grant_id_q;
   assign busy     = (state_q == GRANT) || m_tvalid_q;

   // first requester at or after the round-robin pointer, wrapping modulo NUM_SRC
   always_comb begin
      sel   = rr_ptr_q;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = GW'((int'(rr_ptr_q) + k) % NUM_SRC);
         if (!found && s_tvalid[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   // grant lifecycle, burst count and output register next-state
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = in_xfer ? cnt_q + 8'd1 : cnt_q;
      m_tvalid_d = in_xfer ? 1'b1 : (out_xfer ? 1'b0 : m_tvalid_q);
      m_tdata_d  = in_xfer ? s_tdata[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH] : m_tdata_q;
      if (state_q == IDLE && found) begin
         state_d    = GRANT;
         grant_id_d = sel;
         cnt_d      = '0;
      end
      if (rel) begin
         state_d  = IDLE;
         rr_ptr_d = (grant_id_q == GW'(NUM_SRC - 1)) ? '0 : grant_id_q + GW'(1);
      end
   end

   // state registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
      end
   end
endmodule
